adder_ppn: RTL and testbench
============================

ADDER_PPN -- requirements
Module: adder_ppn

Interface
REQ-001 SHALL have parameter C_IN1, default 12: operand A width, 1..64.
REQ-002 SHALL have parameter C_IN2, default 12: operand B width, 1..64.
REQ-003 SHALL have parameter C_OUT, default 13: result width, 1..65.
REQ-004 SHALL have parameter C_STAGES, default 2: carry-chain pipeline stages, 1..8.
REQ-005 SHALL have parameter C_LANES, default 1: independent parallel adders, 1..16.
REQ-006 SHALL have parameter C_SIGNED, default 0: 0 unsigned, 1 two's-complement operands and result.
REQ-007 SHALL have ports: I_clk in 1, the single clock; I_rst_n in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: I_ce in 1, pipeline advance enable; I_valid in 1, input beat valid.
REQ-009 SHALL have ports: I_a in C_LANES*C_IN1, lane i at [i*C_IN1 +: C_IN1]; I_b in C_LANES*C_IN2, same packing.
REQ-010 SHALL have ports: O_dout out C_LANES*C_OUT, lane-packed; O_valid out 1; O_ovf out C_LANES, per-lane result-did-not-fit flag.

Function
REQ-011 C_W = max(C_IN1,C_IN2) rounded up to a multiple of C_STAGES; C_SEG = C_W/C_STAGES.
REQ-012 Operands SHALL be extended to C_W bits: zero-extension if C_SIGNED=0, sign-extension if C_SIGNED=1.
REQ-013 Stage k (0-based) SHALL add segment k of each lane plus the carry registered by stage k-1 (0 for k=0); the top segment SHALL be computed C_SEG+1 bits wide, giving an exact C_W+1-bit sum.
REQ-014 Lower-segment sums SHALL be delayed and upper operand segments pre-delayed so every lane's full sum appears aligned after exactly C_STAGES advancing cycles.
REQ-015 O_valid SHALL be I_valid delayed by C_STAGES advancing cycles; data registers SHALL advance regardless of I_valid (bubbles carry don't-care data).
REQ-016 With I_ce=0, all data, carry and valid registers SHALL hold; outputs remain stable.
REQ-017 If C_OUT >= C_W+1, result SHALL be the exact sum, zero- or sign-extended per C_SIGNED, and O_ovf SHALL be 0.
REQ-018 If C_OUT < C_W+1, O_ovf[i] SHALL be 1 exactly when lane i's exact sum is outside the C_OUT-bit range for the selected signedness; O_ovf is qualified by O_valid.
REQ-019 Lanes SHALL be fully independent; no carry crosses a lane boundary.
REQ-020 C_STAGES=1 SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-021 I_rst_n low SHALL asynchronously clear all pipeline registers; O_dout, O_valid and O_ovf read 0 during reset and on the first edge after release.
REQ-022 Beats in flight when reset asserts SHALL be discarded; no O_valid pulse for them after release.
REQ-023 Reset release SHALL be taken synchronously by the caller; the block holds no reset synchroniser.

Configuration
REQ-024 Macro ADDER_PPN_SAT_EN defined: when C_OUT < C_W+1 and overflow occurs, O_dout SHALL saturate to the C_OUT-bit max/min (unsigned: all ones; signed: max positive on positive overflow, min negative on negative).
REQ-025 Macro ADDER_PPN_SAT_EN undefined: O_dout SHALL be the C_OUT LSBs of the exact sum (wrap); O_ovf still reported.

Structure
REQ-026 Shared package cnna_arith_pkg SHALL hold the ceil-to-multiple function, C_W/C_SEG derivation function and the saturation-limit constant functions.
REQ-027 One sub-module, adder_fit, SHALL perform per-lane width fitting (extend/wrap/saturate plus overflow flag), combinationally after the last stage register; the output path adds no latency.

Verification
REQ-028 C_IN1=C_IN2=12, C_STAGES=2, unsigned, C_OUT=13: A=0xFFF, B=0x001 valid one beat -> 2 cycles later O_dout=0x1000, O_valid=1, O_ovf=0.
REQ-029 C_STAGES=4, C_IN=16, back-to-back beats (1,1),(0xFFFF,1),(0x8000,0x8000) -> O_dout 0x00002,0x10000,0x10000 on consecutive cycles at latency 4.
REQ-030 C_SIGNED=1, C_IN=8, C_OUT=8, ADDER_PPN_SAT_EN: 100+100 -> 127, O_ovf=1; -100+-100 -> -128, O_ovf=1; without macro -> 0xC8 and 0x38, O_ovf=1.
REQ-031 C_LANES=4: lane operands (0xFFF,1),(5,6),(0,0),(0x800,0x800) -> lanes 0x1000,0x00B,0x000,0x1000; no cross-lane carry.
REQ-032 I_ce low for 3 cycles with two beats in flight -> outputs frozen; after I_ce high, results emerge with correct values and order, no duplicate O_valid.
REQ-033 I_rst_n asserted mid-stream with 2 beats in flight -> O_valid, O_dout, O_ovf immediately 0; no valid output after release until new input + latency.

Source files
------------

// File: rtl/cnna_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnna_arith_pkg
// Brief    : Shared arithmetic helpers: segment-width derivation for pipelined
//            adders and C_OUT-bit saturation limits.
// Revision : 1.0 - initial release
// ============================================================================
package cnna_arith_pkg;

  // Round val up to the next multiple of mult.
  function automatic int ceil_to_mult(input int val, input int mult);
    return ((val + mult - 1) / mult) * mult;
  endfunction

  // Internal operand width: widest operand, padded so it splits evenly.
  function automatic int calc_w(input int in1, input int in2, input int stages);
    return ceil_to_mult((in1 > in2) ? in1 : in2, stages);
  endfunction

  // Bits handled by each carry-chain stage.
  function automatic int calc_seg(input int in1, input int in2, input int stages);
    return calc_w(in1, in2, stages) / stages;
  endfunction

  // Largest representable w-bit value, returned in the low w bits.
  function automatic logic [64:0] sat_max(input int w, input bit sgn);
    return sgn ? ((65'd1 << (w - 1)) - 65'd1) : ((65'd1 << w) - 65'd1);
  endfunction

  // Smallest representable w-bit value, returned in the low w bits.
  function automatic logic [64:0] sat_min(input int w, input bit sgn);
    return sgn ? (65'd1 << (w - 1)) : 65'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_fit.sv
`default_nettype none
// ============================================================================
// Module   : adder_fit
// Brief    : Fits one lane's exact (C_W+1)-bit sum into C_OUT bits: extends
//            when wide enough, otherwise wraps (or saturates when
//            ADDER_PPN_SAT_EN is defined) and raises the overflow flag.
//            Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module adder_fit
  import cnna_arith_pkg::*;
#(
  parameter int C_W      = 12,
  parameter int C_OUT    = 13,
  parameter int C_SIGNED = 0
) (
  input  logic [C_W:0]      sum,
  output logic [C_OUT-1:0]  dout,
  output logic              ovf
);

  if (C_OUT >= C_W + 1) begin : g_wide
    // Exact sum always fits; only extension is needed.
    if (C_SIGNED != 0) begin : g_sext
      assign dout = C_OUT'($signed(sum));
    end else begin : g_zext
      assign dout = C_OUT'(sum);
    end
    assign ovf = 1'b0;
  end else begin : g_narrow
    logic             fit_err;
    logic [C_OUT-1:0] wrap;

    assign wrap = sum[C_OUT-1:0];

    if (C_SIGNED != 0) begin : g_sgn
      // Everything from the result sign bit upward must be a pure sign run.
      logic [C_W-C_OUT+1:0] top;
      assign top     = sum[C_W:C_OUT-1];
      assign fit_err = ~((&top) | ~(|top));
    end else begin : g_uns
      assign fit_err = |sum[C_W:C_OUT];
    end

`ifdef ADDER_PPN_SAT_EN
    localparam logic [64:0] C_MAX = sat_max(C_OUT, C_SIGNED != 0);
    localparam logic [64:0] C_MIN = sat_min(C_OUT, C_SIGNED != 0);

    // Clamp toward the overflow direction; the sum's MSB gives its sign.
    always_comb begin
      dout = wrap;
      if (fit_err) begin
        dout = ((C_SIGNED != 0) && sum[C_W]) ? C_MIN[C_OUT-1:0] : C_MAX[C_OUT-1:0];
      end
    end
`else
    assign dout = wrap;
`endif

    assign ovf = fit_err;
  end

endmodule
`default_nettype wire

// File: rtl/adder_ppn.sv
`default_nettype none
// ============================================================================
// Module   : adder_ppn
// Brief    : Multi-lane adder with the carry chain split over C_STAGES
//            pipeline stages. Upper operand segments ride along the pipe,
//            finished lower sum segments accumulate, so every lane's exact
//            sum is aligned after C_STAGES advancing cycles.
//            Option macro: ADDER_PPN_SAT_EN (saturate instead of wrap).
// Revision : 1.0 - initial release
// ============================================================================
module adder_ppn
  import cnna_arith_pkg::*;
#(
  parameter int C_IN1    = 12,
  parameter int C_IN2    = 12,
  parameter int C_OUT    = 13,
  parameter int C_STAGES = 2,
  parameter int C_LANES  = 1,
  parameter int C_SIGNED = 0
) (
  input  logic                       I_clk,
  input  logic                       I_rst_n,
  input  logic                       I_ce,
  input  logic                       I_valid,
  input  logic [C_LANES*C_IN1-1:0]   I_a,
  input  logic [C_LANES*C_IN2-1:0]   I_b,
  output logic [C_LANES*C_OUT-1:0]   O_dout,
  output logic                       O_valid,
  output logic [C_LANES-1:0]         O_ovf
);

  localparam int C_W   = calc_w(C_IN1, C_IN2, C_STAGES);
  localparam int C_SEG = calc_seg(C_IN1, C_IN2, C_STAGES);

  logic [C_STAGES-1:0] v_q;
  logic                valid_out;

  // Valid travels alongside the data and is the only thing beats depend on.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      v_q <= '0;
    end else if (I_ce) begin
      v_q[0] <= I_valid;
      for (int j = 1; j < C_STAGES; j++) v_q[j] <= v_q[j-1];
    end
  end

  assign valid_out = v_q[C_STAGES-1];
  assign O_valid   = valid_out;

  for (genvar i = 0; i < C_LANES; i++) begin : g_lane
    logic [C_IN1-1:0] a_lane;
    logic [C_IN2-1:0] b_lane;
    logic [C_W-1:0]   a_ext;
    logic [C_W-1:0]   b_ext;
    logic [C_W:0]     sum_full;
    logic [C_OUT-1:0] fit_dout;
    logic             fit_ovf;

    assign a_lane = I_a[i*C_IN1 +: C_IN1];
    assign b_lane = I_b[i*C_IN2 +: C_IN2];

    if (C_SIGNED != 0) begin : g_sext
      assign a_ext = C_W'($signed(a_lane));
      assign b_ext = C_W'($signed(b_lane));
    end else begin : g_zext
      assign a_ext = C_W'(a_lane);
      assign b_ext = C_W'(b_lane);
    end

    for (genvar k = 0; k < C_STAGES; k++) begin : g_stage
      localparam int LO = k * C_SEG;   // sum bits already finished
      localparam int RW = C_W - LO;    // operand bits still to add

      logic [RW-1:0] a_in;
      logic [RW-1:0] b_in;
      logic          c_in;

      if (k == 0) begin : g_in0
        assign a_in = a_ext;
        assign b_in = b_ext;
        assign c_in = 1'b0;
      end else begin : g_inn
        assign a_in = g_stage[k-1].g_mid.a_q;
        assign b_in = g_stage[k-1].g_mid.b_q;
        assign c_in = g_stage[k-1].g_mid.c_q;
      end

      if (k < C_STAGES - 1) begin : g_mid
        logic [C_SEG:0]         seg;
        logic [RW-C_SEG-1:0]    a_q;
        logic [RW-C_SEG-1:0]    b_q;
        logic                   c_q;
        logic [LO+C_SEG-1:0]    s_q;

        // Lower segments are plain unsigned adds; sign only matters at the top.
        assign seg = {1'b0, a_in[C_SEG-1:0]} + {1'b0, b_in[C_SEG-1:0]}
                   + {{C_SEG{1'b0}}, c_in};

        // Forward carry and the not-yet-added upper operand bits.
        always_ff @(posedge I_clk or negedge I_rst_n) begin
          if (!I_rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= 1'b0;
          end else if (I_ce) begin
            a_q <= a_in[RW-1:C_SEG];
            b_q <= b_in[RW-1:C_SEG];
            c_q <= seg[C_SEG];
          end
        end

        if (k == 0) begin : g_first
          // Start the partial sum with the lowest segment.
          always_ff @(posedge I_clk or negedge I_rst_n) begin
            if (!I_rst_n)  s_q <= '0;
            else if (I_ce) s_q <= seg[C_SEG-1:0];
          end
        end else begin : g_chain
          // Append this segment above the delayed lower segments.
          always_ff @(posedge I_clk or negedge I_rst_n) begin
            if (!I_rst_n)  s_q <= '0;
            else if (I_ce) s_q <= {seg[C_SEG-1:0], g_stage[k-1].g_mid.s_q};
          end
        end
      end else begin : g_top
        logic [C_SEG:0] top;
        logic [C_W:0]   s_q;

        // One extra bit on the top segment makes the whole sum exact.
        if (C_SIGNED != 0) begin : g_sgn
          assign top = {a_in[C_SEG-1], a_in} + {b_in[C_SEG-1], b_in}
                     + {{C_SEG{1'b0}}, c_in};
        end else begin : g_uns
          assign top = {1'b0, a_in} + {1'b0, b_in} + {{C_SEG{1'b0}}, c_in};
        end

        if (k == 0) begin : g_solo
          // Single stage: one registered adder.
          always_ff @(posedge I_clk or negedge I_rst_n) begin
            if (!I_rst_n)  s_q <= '0;
            else if (I_ce) s_q <= top;
          end
        end else begin : g_join
          // Final stage: top segment joins the aligned lower sum.
          always_ff @(posedge I_clk or negedge I_rst_n) begin
            if (!I_rst_n)  s_q <= '0;
            else if (I_ce) s_q <= {top, g_stage[k-1].g_mid.s_q};
          end
        end
      end
    end

    assign sum_full = g_stage[C_STAGES-1].g_top.s_q;

    adder_fit #(
      .C_W      (C_W),
      .C_OUT    (C_OUT),
      .C_SIGNED (C_SIGNED)
    ) u_fit (
      .sum  (sum_full),
      .dout (fit_dout),
      .ovf  (fit_ovf)
    );

    assign O_dout[i*C_OUT +: C_OUT] = valid_out ? fit_dout : '0;
    assign O_ovf[i]                 = valid_out & fit_ovf;
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_ppn.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_ppn
// Brief    : Self-checking bench for adder_ppn. Three configurations:
//            dut0 unsigned 12+12->13, 2 stages, 4 lanes
//            dut1 signed 8+8->8, 3 stages (padded width 9), 2 lanes
//            dut2 unsigned 16+16->17, 4 stages, 1 lane
//            Expected results use ADDER_PPN_SAT_EN to pick saturate/wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_ppn;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ce    = 1'b0;

  always #5 clk = ~clk;

  logic        v0, ov0;
  logic [47:0] a0, b0;
  logic [51:0] d0;
  logic [3:0]  f0;

  logic        v1, ov1;
  logic [15:0] a1, b1;
  logic [15:0] d1;
  logic [1:0]  f1;

  logic        v2, ov2;
  logic [15:0] a2, b2;
  logic [16:0] d2;
  logic [0:0]  f2;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  adder_ppn #(.C_IN1(12), .C_IN2(12), .C_OUT(13), .C_STAGES(2), .C_LANES(4), .C_SIGNED(0)) dut0 (
    .I_clk(clk), .I_rst_n(rst_n), .I_ce(ce), .I_valid(v0), .I_a(a0), .I_b(b0),
    .O_dout(d0), .O_valid(ov0), .O_ovf(f0));

  adder_ppn #(.C_IN1(8), .C_IN2(8), .C_OUT(8), .C_STAGES(3), .C_LANES(2), .C_SIGNED(1)) dut1 (
    .I_clk(clk), .I_rst_n(rst_n), .I_ce(ce), .I_valid(v1), .I_a(a1), .I_b(b1),
    .O_dout(d1), .O_valid(ov1), .O_ovf(f1));

  adder_ppn #(.C_IN1(16), .C_IN2(16), .C_OUT(17), .C_STAGES(4), .C_LANES(1), .C_SIGNED(0)) dut2 (
    .I_clk(clk), .I_rst_n(rst_n), .I_ce(ce), .I_valid(v2), .I_a(a2), .I_b(b2),
    .O_dout(d2), .O_valid(ov2), .O_ovf(f2));

  // Reference results as {ovf, dout}, straight from integer arithmetic.
  function automatic logic [55:0] ref0(input logic [47:0] a, input logic [47:0] b);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*13 +: 13] = 13'(a[i*12 +: 12]) + 13'(b[i*12 +: 12]);
    return r;
  endfunction

  function automatic logic [17:0] ref1(input logic [15:0] a, input logic [15:0] b);
    logic [17:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      s = int'($signed(a[i*8 +: 8])) + int'($signed(b[i*8 +: 8]));
      r[i*8 +: 8] = s[7:0];
      if (s > 127 || s < -128) begin
        r[16+i] = 1'b1;
`ifdef ADDER_PPN_SAT_EN
        r[i*8 +: 8] = (s > 0) ? 8'h7F : 8'h80;
`endif
      end
    end
    return r;
  endfunction

  function automatic logic [17:0] ref2(input logic [15:0] a, input logic [15:0] b);
    return {1'b0, 17'(a) + 17'(b)};
  endfunction

  // Behavioural latency model: a delay line of expected beats per DUT.
  logic        m0_v [2];
  logic [55:0] m0_e [2];
  logic        m1_v [3];
  logic [17:0] m1_e [3];
  logic        m2_v [4];
  logic [17:0] m2_e [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 2; j++) begin m0_v[j] <= 1'b0; m0_e[j] <= '0; end
      for (int j = 0; j < 3; j++) begin m1_v[j] <= 1'b0; m1_e[j] <= '0; end
      for (int j = 0; j < 4; j++) begin m2_v[j] <= 1'b0; m2_e[j] <= '0; end
    end else if (ce) begin
      for (int j = 1; j < 2; j++) begin m0_v[j] <= m0_v[j-1]; m0_e[j] <= m0_e[j-1]; end
      for (int j = 1; j < 3; j++) begin m1_v[j] <= m1_v[j-1]; m1_e[j] <= m1_e[j-1]; end
      for (int j = 1; j < 4; j++) begin m2_v[j] <= m2_v[j-1]; m2_e[j] <= m2_e[j-1]; end
      m0_v[0] <= v0; m0_e[0] <= ref0(a0, b0);
      m1_v[0] <= v1; m1_e[0] <= ref1(a1, b1);
      m2_v[0] <= v2; m2_e[0] <= ref2(a2, b2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    a0 = '1; b0 = '1; a1 = '1; b1 = '1; a2 = '1; b2 = '1;
    repeat (3) tick();
    chk_cnt++; if (ov0 !== 1'b0) $display("FAIL rst_valid0 got=%b exp=0", ov0); else pass_cnt++;
    chk_cnt++; if (d0 !== 52'd0) $display("FAIL rst_dout0 got=%h exp=0", d0); else pass_cnt++;
    chk_cnt++; if (f0 !== 4'd0) $display("FAIL rst_ovf0 got=%b exp=0", f0); else pass_cnt++;
    chk_cnt++; if (ov1 !== 1'b0 || d1 !== 16'd0 || f1 !== 2'd0)
      $display("FAIL rst_dut1 got v=%b d=%h f=%b exp all 0", ov1, d1, f1); else pass_cnt++;
    chk_cnt++; if (ov2 !== 1'b0 || d2 !== 17'd0 || f2 !== 1'b0)
      $display("FAIL rst_dut2 got v=%b d=%h f=%b exp all 0", ov2, d2, f2); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    chk_cnt++; if (ov0 !== 1'b0 || d0 !== 52'd0 || f0 !== 4'd0)
      $display("FAIL rel_edge0 got v=%b d=%h f=%b exp all 0", ov0, d0, f0); else pass_cnt++;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (4) tick();
  endtask

  task automatic test_lanes();
    a0 = {12'h800, 12'h000, 12'h005, 12'hFFF};
    b0 = {12'h800, 12'h000, 12'h006, 12'h001};
    v0 = 1'b1;
    tick();
    v0 = 1'b0;
    chk_cnt++; if (ov0 !== 1'b0) $display("FAIL lanes_early got=%b exp=0", ov0); else pass_cnt++;
    tick();
    chk_cnt++; if (ov0 !== 1'b1) $display("FAIL lanes_valid got=%b exp=1", ov0); else pass_cnt++;
    chk_cnt++; if (d0 !== {13'h1000, 13'h0000, 13'h000B, 13'h1000})
      $display("FAIL lanes_dout got=%h exp=%h", d0, {13'h1000, 13'h0000, 13'h000B, 13'h1000}); else pass_cnt++;
    chk_cnt++; if (f0 !== 4'b0000) $display("FAIL lanes_ovf got=%b exp=0000", f0); else pass_cnt++;
    tick();
    chk_cnt++; if (ov0 !== 1'b0) $display("FAIL lanes_dup got=%b exp=0", ov0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_d [3];
    exp_d[0] = 17'h00002; exp_d[1] = 17'h10000; exp_d[2] = 17'h10000;
    v2 = 1'b1; a2 = 16'h0001; b2 = 16'h0001; tick();
    a2 = 16'hFFFF; b2 = 16'h0001; tick();
    a2 = 16'h8000; b2 = 16'h8000; tick();
    v2 = 1'b0;
    chk_cnt++; if (ov2 !== 1'b0) $display("FAIL b2b_early got=%b exp=0", ov2); else pass_cnt++;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk_cnt++; if (ov2 !== 1'b1 || d2 !== exp_d[n] || f2 !== 1'b0)
        $display("FAIL b2b_beat%0d got v=%b d=%h f=%b exp v=1 d=%h f=0", n, ov2, d2, f2, exp_d[n]);
      else pass_cnt++;
    end
    tick();
    chk_cnt++; if (ov2 !== 1'b0) $display("FAIL b2b_tail got=%b exp=0", ov2); else pass_cnt++;
  endtask

  task automatic test_signed_fit();
    logic [15:0] exp_d;
`ifdef ADDER_PPN_SAT_EN
    exp_d = {8'h80, 8'h7F};
`else
    exp_d = {8'h38, 8'hC8};
`endif
    a1 = {8'h9C, 8'h64}; b1 = {8'h9C, 8'h64};   // lane0 100+100, lane1 -100+-100
    v1 = 1'b1; tick(); v1 = 1'b0;
    tick();
    chk_cnt++; if (ov1 !== 1'b0) $display("FAIL sgn_early got=%b exp=0", ov1); else pass_cnt++;
    tick();
    chk_cnt++; if (ov1 !== 1'b1) $display("FAIL sgn_valid got=%b exp=1", ov1); else pass_cnt++;
    chk_cnt++; if (d1 !== exp_d) $display("FAIL sgn_dout got=%h exp=%h", d1, exp_d); else pass_cnt++;
    chk_cnt++; if (f1 !== 2'b11) $display("FAIL sgn_ovf got=%b exp=11", f1); else pass_cnt++;
    a1 = {8'hFB, 8'h80}; b1 = {8'h03, 8'h7F};   // lane0 -128+127=-1, lane1 -5+3=-2
    v1 = 1'b1; tick(); v1 = 1'b0;
    repeat (2) tick();
    chk_cnt++; if (ov1 !== 1'b1 || d1 !== 16'hFEFF || f1 !== 2'b00)
      $display("FAIL sgn_fit got v=%b d=%h f=%b exp v=1 d=feff f=00", ov1, d1, f1); else pass_cnt++;
  endtask

  task automatic test_ce_stall();
    int vcount;
    vcount = 0;
    ce = 1'b1;
    v0 = 1'b1; a0 = 48'({$urandom(), $urandom()}); b0 = 48'({$urandom(), $urandom()}); tick();
    a0 = 48'({$urandom(), $urandom()}); b0 = 48'({$urandom(), $urandom()}); tick();
    v0 = 1'b0; ce = 1'b0;
    a0 = '1; b0 = '1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk_cnt++; if (ov0 !== 1'b1) $display("FAIL stall_valid%0d got=%b exp=1", n, ov0); else pass_cnt++;
      chk_cnt++; if ({f0, d0} !== m0_e[1]) $display("FAIL stall_data%0d got=%h exp=%h", n, {f0, d0}, m0_e[1]); else pass_cnt++;
    end
    ce = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (ov0 === 1'b1) vcount++;
      chk_cnt++; if (ov0 !== m0_v[1]) $display("FAIL resume_valid%0d got=%b exp=%b", n, ov0, m0_v[1]); else pass_cnt++;
      if (m0_v[1]) begin
        chk_cnt++; if ({f0, d0} !== m0_e[1]) $display("FAIL resume_data%0d got=%h exp=%h", n, {f0, d0}, m0_e[1]); else pass_cnt++;
      end
    end
    chk_cnt++; if (vcount !== 1) $display("FAIL resume_count got=%0d exp=1", vcount); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      ce = ($urandom_range(0, 7) != 0);
      v0 = 1'($urandom()); v1 = 1'($urandom()); v2 = 1'($urandom());
      a0 = 48'({$urandom(), $urandom()}); b0 = 48'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) a0 = '1;
      a1 = 16'($urandom()); b1 = 16'($urandom());
      a2 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom());
      b2 = 16'($urandom());
      tick();
      chk_cnt++; if (ov0 !== m0_v[1]) $display("FAIL rnd0_valid c%0d got=%b exp=%b", n, ov0, m0_v[1]); else pass_cnt++;
      if (m0_v[1]) begin
        chk_cnt++; if ({f0, d0} !== m0_e[1]) $display("FAIL rnd0_data c%0d got=%h exp=%h", n, {f0, d0}, m0_e[1]); else pass_cnt++;
      end
      chk_cnt++; if (ov1 !== m1_v[2]) $display("FAIL rnd1_valid c%0d got=%b exp=%b", n, ov1, m1_v[2]); else pass_cnt++;
      if (m1_v[2]) begin
        chk_cnt++; if ({f1, d1} !== m1_e[2]) $display("FAIL rnd1_data c%0d got=%h exp=%h", n, {f1, d1}, m1_e[2]); else pass_cnt++;
      end
      chk_cnt++; if (ov2 !== m2_v[3]) $display("FAIL rnd2_valid c%0d got=%b exp=%b", n, ov2, m2_v[3]); else pass_cnt++;
      if (m2_v[3]) begin
        chk_cnt++; if ({f2, d2} !== m2_e[3]) $display("FAIL rnd2_data c%0d got=%h exp=%h", n, {f2, d2}, m2_e[3]); else pass_cnt++;
      end
    end
    ce = 1'b1; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    ce = 1'b1;
    v0 = 1'b1; a0 = {4{12'hFFF}}; b0 = {4{12'h001}}; tick();
    a0 = {4{12'h123}}; b0 = {4{12'h456}}; tick();
    v0 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (ov0 !== 1'b0 || d0 !== 52'd0 || f0 !== 4'd0)
      $display("FAIL midrst_now got v=%b d=%h f=%b exp all 0", ov0, d0, f0); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk_cnt++; if (ov0 !== 1'b0) $display("FAIL midrst_ghost%0d got=%b exp=0", n, ov0); else pass_cnt++;
    end
    v0 = 1'b1; a0 = {4{12'h00F}}; b0 = {4{12'h001}}; tick();
    v0 = 1'b0; tick();
    chk_cnt++; if (ov0 !== 1'b1 || d0 !== {4{13'h0010}})
      $display("FAIL midrst_new got v=%b d=%h exp v=1 d=%h", ov0, d0, {4{13'h0010}}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_back_to_back();
    test_signed_fit();
    test_ce_stall();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
